apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

- Round-robin APB master: shares one APB bus among `NREQ` requesters and drives the SETUP/ACCESS sequence to the APB slaves on it (GPIO and peers).
- Per transfer:
  - captures the winning requester's address, data and direction;
  - returns read data plus a one-cycle completion pulse;
  - aborts with an error if the slave withholds `pready` beyond a bounded wait.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `AW`, 5, APB address width
- `DW`, 32, APB data width
- `TIMEOUT`, 15, maximum ACCESS cycles before abort (≥1)

Ports:
- `pclk`  in  1  clock; every register updates on its rising edge
- `rst`  in  1  reset, synchronous, active-low
- `req`  in  NREQ  per-requester level request, held until `done` with own `gnt`
- `req_write`  in  NREQ  1 = write, 0 = read
- `req_addr`  in  NREQ*AW  requester i at `[i*AW +: AW]`
- `req_wdata`  in  NREQ*DW  requester i at `[i*DW +: DW]`
- `gnt`  out  NREQ  one-hot owner of current transfer
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  timeout abort, valid with `done`
- `rdata`  out  DW  read data, valid with `done`
- `psel`, `penable`, `pwrite`  out  1  APB control
- `paddr`  out  AW  APB address
- `pwdata`  out  DW  APB write data
- `pready`  in  1  slave ready
- `prdata`  in  DW  slave read data

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- Reset (`rst`=0 at an edge):
  - state IDLE; all outputs 0;
  - round-robin pointer set so requester 0 has top priority;
  - wait counter 0.
- IDLE:
  - Arbitrates only when `done`=0 and `|req`=1.
  - Winner is the first requester at or after (last winner + 1) mod `NREQ`.
  - On winning edge:
    - `gnt` = one-hot winner;
    - capture `req_addr`/`req_wdata`/`req_write` into `paddr`/`pwdata`/`pwrite`;
    - `psel`=1, `penable`=0;
    - pointer = winner;
    - next state SETUP.
- SETUP: one cycle; next edge sets `penable`=1, clears wait counter, enters ACCESS.
- ACCESS, at each edge:
  - `pready`=1:
    - `psel`=`penable`=0, `done`=1, `err`=0;
    - `rdata` = `prdata` if read, else 0;
    - next state IDLE.
  - `pready`=0 and counter = `TIMEOUT`-1:
    - abort: `psel`=`penable`=0, `done`=1, `err`=1, `rdata`=0;
    - next state IDLE.
  - Otherwise: counter +1, remain in ACCESS.
- Completion cycle:
  - `gnt` stays asserted during the `done` cycle and clears at the following edge.
  - `done`, `err` and `rdata` are single-cycle; `rdata` and `err` return to 0 after.
- Requester inputs are ignored outside the IDLE arbitration edge; changes after grant have no effect.
- A requester still holding `req` after its `done` is re-arbitrated normally and may win again if no other requester is pending.
- Counter width: `$clog2(TIMEOUT+1)`; it never wraps.

## Timing
- Request sampled at edge t (IDLE, `done`=0):
  - SETUP during t..t+1;
  - ACCESS from t+1;
  - with zero wait states, `done` is high after edge t+2.
- Minimum transfer period per requester: 4 cycles (SETUP, ACCESS, done/IDLE, arbitration).
- APB compliance:
  - `paddr`, `pwrite`, `pwdata` stable from SETUP until completion;
  - `penable` never high without `psel`.
- Simultaneous requests resolve purely by pointer; `done` and a new grant are never issued at the same edge.
- Reset mid-transfer:
  - bus drops at the next edge;
  - no `done` is issued;
  - the aborted transfer is lost.
- Slaves that never assert `pready` on writes complete through the timeout path with `err`=1.

## Structure
- Package `apb_pkg` holds:
  - the state typedef (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10);
  - default `AW`/`DW` constants.
- Sub-module `rr_arbiter`:
  - combinational one-hot round-robin pick from `req` and pointer;
  - the pointer register stays in the parent.

## Test plan
- Write, requester 0, addr 5'h03, data 32'hDEADBEEF, `pready`=1 on first ACCESS -> `psel` at t+1, `penable` at t+2, `done`=1 after t+2 with `err`=0, `gnt`=4'b0001.
- Read, requester 2, addr 5'h03, slave holds `pready` low 2 cycles then returns 32'hDEADBEEF -> 3 ACCESS cycles, `rdata`=32'hDEADBEEF with `done`, `gnt`=4'b0100.
- All four `req` held high, zero-wait slave -> grants 0,1,2,3,0 in order, one `done` every 4 cycles, address/data always match the granted requester.
- `pready` stuck low, `TIMEOUT`=15 -> exactly 15 ACCESS cycles, then `done`=`err`=1, `rdata`=0, `psel`=`penable`=0.
- `rst`=0 during ACCESS of requester 2 -> all outputs 0 next edge, no `done`; after release, requesters 1 and 3 requesting -> requester 1 granted first.
- Requester keeps `req` high after `done` while requester 3 idle -> no grant in the `done` cycle, regrant to same requester at the following edge.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the round-robin APB master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int APB_AW_DEFAULT = 5;
    localparam int APB_DW_DEFAULT = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after (i_ptr + 1) mod NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx
);

    always_comb begin : pick
        logic [PW-1:0] idx;
        logic          found;
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        idx   = '0;
        // i_ptr holds the last winner, so the scan begins one past it
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(i_ptr) + k) % NREQ);
            if (!found && i_req[idx]) begin
                found      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: arbitrates NREQ requesters onto one APB bus and
// runs the SETUP/ACCESS handshake with a bounded wait on pready.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = APB_AW_DEFAULT,
    parameter int DW      = APB_DW_DEFAULT,
    parameter int TIMEOUT = 15
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic               done,
    output logic               err,
    output logic [DW-1:0]      rdata,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic               pready,
    input  logic [DW-1:0]      prdata
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_RESET = PW'(NREQ - 1);

    apb_state_e      r_state, w_stateNext;
    logic [NREQ-1:0] r_gnt, w_gntNext;
    logic            r_done, w_doneNext;
    logic            r_err, w_errNext;
    logic [DW-1:0]   r_rdata, w_rdataNext;
    logic            r_psel, w_pselNext;
    logic            r_penable, w_penableNext;
    logic            r_pwrite, w_pwriteNext;
    logic [AW-1:0]   r_paddr, w_paddrNext;
    logic [DW-1:0]   r_pwdata, w_pwdataNext;
    logic [CW-1:0]   r_cnt, w_cntNext;
    logic [PW-1:0]   r_ptr, w_ptrNext;

    logic [NREQ-1:0] w_arbGnt;
    logic [PW-1:0]   w_arbIdx;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_arbGnt),
        .o_idx (w_arbIdx)
    );

    always_comb begin
        w_stateNext   = r_state;
        w_gntNext     = r_gnt;
        w_doneNext    = 1'b0;
        w_errNext     = 1'b0;
        w_rdataNext   = '0;
        w_pselNext    = r_psel;
        w_penableNext = r_penable;
        w_pwriteNext  = r_pwrite;
        w_paddrNext   = r_paddr;
        w_pwdataNext  = r_pwdata;
        w_cntNext     = r_cnt;
        w_ptrNext     = r_ptr;

        case (r_state)
            IDLE: begin
                w_gntNext = '0;
                // the completion cycle is never also an arbitration cycle
                if (!r_done && (|req)) begin
                    w_gntNext     = w_arbGnt;
                    w_pwriteNext  = req_write[w_arbIdx];
                    for (int i = 0; i < NREQ; i++) begin
                        if (w_arbGnt[i]) begin
                            w_paddrNext  = req_addr[i*AW +: AW];
                            w_pwdataNext = req_wdata[i*DW +: DW];
                        end
                    end
                    w_pselNext    = 1'b1;
                    w_penableNext = 1'b0;
                    w_ptrNext     = w_arbIdx;
                    w_stateNext   = SETUP;
                end
            end
            SETUP: begin
                w_penableNext = 1'b1;
                w_cntNext     = '0;
                w_stateNext   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    w_pselNext    = 1'b0;
                    w_penableNext = 1'b0;
                    w_doneNext    = 1'b1;
                    w_rdataNext   = r_pwrite ? '0 : prdata;
                    w_stateNext   = IDLE;
                end else if (r_cnt == LAST_WAIT) begin
                    w_pselNext    = 1'b0;
                    w_penableNext = 1'b0;
                    w_doneNext    = 1'b1;
                    w_errNext     = 1'b1;
                    w_stateNext   = IDLE;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            default: begin
                w_stateNext   = IDLE;
                w_gntNext     = '0;
                w_pselNext    = 1'b0;
                w_penableNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_cnt     <= '0;
            r_ptr     <= PTR_RESET;
        end else begin
            r_state   <= w_stateNext;
            r_gnt     <= w_gntNext;
            r_done    <= w_doneNext;
            r_err     <= w_errNext;
            r_rdata   <= w_rdataNext;
            r_psel    <= w_pselNext;
            r_penable <= w_penableNext;
            r_pwrite  <= w_pwriteNext;
            r_paddr   <= w_paddrNext;
            r_pwdata  <= w_pwdataNext;
            r_cnt     <= w_cntNext;
            r_ptr     <= w_ptrNext;
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign err     = r_err;
    assign rdata   = r_rdata;
    assign psel    = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign paddr   = r_paddr;
    assign pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: hand-computed expectations for grants,
// APB phases, completion, timeout abort, reset mid-transfer and regrant.
module tb_apb_master_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic               pclk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic               done;
    logic               err;
    logic [DW-1:0]      rdata;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic               pready;
    logic [DW-1:0]      prdata;

    int checks;
    int failures;

    apb_master_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic rq);
        req_write[idx]           = wr;
        req_addr[idx*AW +: AW]   = addr;
        req_wdata[idx*DW +: DW]  = data;
        req[idx]                 = rq;
    endtask

    // advance one rising edge, then settle so sampling and driving stay off the edge
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin : main
        int accessCycles;
        bit sawDone;
        logic [3:0] expGnt;

        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;

        $display("[TB] reset state");
        resetDut();
        checkOutput("rst_gnt", 64'(gnt), 64'h0);
        checkOutput("rst_psel", 64'(psel), 64'h0);
        checkOutput("rst_penable", 64'(penable), 64'h0);
        checkOutput("rst_done", 64'(done), 64'h0);
        checkOutput("rst_err", 64'(err), 64'h0);
        checkOutput("rst_rdata", 64'(rdata), 64'h0);
        checkOutput("rst_paddr", 64'(paddr), 64'h0);
        checkOutput("rst_pwdata", 64'(pwdata), 64'h0);
        checkOutput("rst_pwrite", 64'(pwrite), 64'h0);

        $display("[TB] zero-wait write from requester 0");
        pready = 1'b1;
        applyStimulus(0, 1'b1, 5'h03, 32'hDEADBEEF, 1'b1);
        step();
        checkOutput("w_gnt", 64'(gnt), 64'h1);
        checkOutput("w_setup_psel", 64'(psel), 64'h1);
        checkOutput("w_setup_penable", 64'(penable), 64'h0);
        checkOutput("w_paddr", 64'(paddr), 64'h03);
        checkOutput("w_pwdata", 64'(pwdata), 64'hDEADBEEF);
        checkOutput("w_pwrite", 64'(pwrite), 64'h1);
        step();
        checkOutput("w_access_penable", 64'(penable), 64'h1);
        checkOutput("w_access_done", 64'(done), 64'h0);
        step();
        checkOutput("w_done", 64'(done), 64'h1);
        checkOutput("w_err", 64'(err), 64'h0);
        checkOutput("w_done_psel", 64'(psel), 64'h0);
        checkOutput("w_done_penable", 64'(penable), 64'h0);
        checkOutput("w_done_gnt", 64'(gnt), 64'h1);
        checkOutput("w_rdata_zero", 64'(rdata), 64'h0);
        req = '0;
        step();
        checkOutput("w_after_done", 64'(done), 64'h0);
        checkOutput("w_after_gnt", 64'(gnt), 64'h0);

        $display("[TB] read from requester 2 with two wait states");
        pready = 1'b0;
        prdata = 32'h12345678;
        applyStimulus(2, 1'b0, 5'h03, 32'h0, 1'b1);
        step();
        checkOutput("r_gnt", 64'(gnt), 64'h4);
        checkOutput("r_pwrite", 64'(pwrite), 64'h0);
        step();
        checkOutput("r_acc1_penable", 64'(penable), 64'h1);
        step();
        checkOutput("r_acc2_done", 64'(done), 64'h0);
        checkOutput("r_acc2_penable", 64'(penable), 64'h1);
        step();
        checkOutput("r_acc3_done", 64'(done), 64'h0);
        pready = 1'b1;
        prdata = 32'hDEADBEEF;
        step();
        checkOutput("r_done", 64'(done), 64'h1);
        checkOutput("r_rdata", 64'(rdata), 64'hDEADBEEF);
        checkOutput("r_done_gnt", 64'(gnt), 64'h4);
        checkOutput("r_err", 64'(err), 64'h0);
        pready = 1'b0;
        prdata = '0;
        req    = '0;
        step();
        checkOutput("r_rdata_clear", 64'(rdata), 64'h0);
        checkOutput("r_gnt_clear", 64'(gnt), 64'h0);

        $display("[TB] all four requesting, zero-wait slave");
        resetDut();
        pready = 1'b1;
        prdata = 32'hCAFE0000;
        for (int i = 0; i < NREQ; i++)
            applyStimulus(i, i[0], 5'(8 + i), 32'hA0000000 + 32'(i), 1'b1);
        for (int k = 0; k < 5; k++) begin
            expGnt = 4'b0001 << (k % NREQ);
            step();
            checkOutput($sformatf("rr%0d_gnt", k), 64'(gnt), 64'(expGnt));
            checkOutput($sformatf("rr%0d_paddr", k), 64'(paddr), 64'(8 + (k % NREQ)));
            checkOutput($sformatf("rr%0d_pwdata", k), 64'(pwdata),
                        64'(32'hA0000000 + 32'(k % NREQ)));
            step();
            step();
            checkOutput($sformatf("rr%0d_done", k), 64'(done), 64'h1);
            checkOutput($sformatf("rr%0d_rdata", k), 64'(rdata),
                        ((k % 2) == 1) ? 64'h0 : 64'hCAFE0000);
            step();
            checkOutput($sformatf("rr%0d_gap_gnt", k), 64'(gnt), 64'h0);
        end
        req    = '0;
        prdata = '0;

        $display("[TB] timeout abort on a stuck write");
        pready = 1'b0;
        step();
        applyStimulus(1, 1'b1, 5'h1F, 32'h55AA55AA, 1'b1);
        step();
        checkOutput("to_gnt", 64'(gnt), 64'h2);
        checkOutput("to_paddr", 64'(paddr), 64'h1F);
        accessCycles = 0;
        sawDone      = 1'b0;
        for (int n = 0; n < 40 && !sawDone; n++) begin
            step();
            if (psel && penable) accessCycles++;
            if (done) sawDone = 1'b1;
        end
        checkOutput("to_seen_done", 64'(sawDone), 64'h1);
        checkOutput("to_access_cycles", 64'(accessCycles), 64'(TIMEOUT));
        checkOutput("to_err", 64'(err), 64'h1);
        checkOutput("to_rdata", 64'(rdata), 64'h0);
        checkOutput("to_psel", 64'(psel), 64'h0);
        checkOutput("to_penable", 64'(penable), 64'h0);
        checkOutput("to_done_gnt", 64'(gnt), 64'h2);
        req = '0;
        step();
        checkOutput("to_err_clear", 64'(err), 64'h0);
        checkOutput("to_done_clear", 64'(done), 64'h0);

        $display("[TB] reset during ACCESS of requester 2");
        applyStimulus(2, 1'b0, 5'h07, 32'h0, 1'b1);
        step();
        checkOutput("mr_gnt", 64'(gnt), 64'h4);
        step();
        checkOutput("mr_access", 64'(penable), 64'h1);
        rst = 1'b0;
        step();
        checkOutput("mr_psel", 64'(psel), 64'h0);
        checkOutput("mr_penable", 64'(penable), 64'h0);
        checkOutput("mr_gnt_zero", 64'(gnt), 64'h0);
        checkOutput("mr_no_done", 64'(done), 64'h0);
        rst = 1'b1;
        req = 4'b1010;
        step();
        checkOutput("mr_regnt", 64'(gnt), 64'h2);
        checkOutput("mr_regnt_done", 64'(done), 64'h0);
        req    = '0;
        pready = 1'b1;
        step();
        step();
        checkOutput("mr_done", 64'(done), 64'h1);
        step();

        $display("[TB] held request regranted after completion");
        req = 4'b0001;
        step();
        checkOutput("hg_gnt", 64'(gnt), 64'h1);
        step();
        step();
        checkOutput("hg_done", 64'(done), 64'h1);
        step();
        checkOutput("hg_no_grant_gap", 64'(gnt), 64'h0);
        checkOutput("hg_gap_psel", 64'(psel), 64'h0);
        step();
        checkOutput("hg_regrant", 64'(gnt), 64'h1);
        checkOutput("hg_regrant_psel", 64'(psel), 64'h1);
        req = '0;
        step();
        step();
        checkOutput("hg_done2", 64'(done), 64'h1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
